// File: rtl/hw_seq_ctrl.sv
// hw_seq_ctrl: beat generator and micro-control decoder for console and run modes
module hw_seq_ctrl #(
    parameter int NREG = 4,
    parameter int OPW = 4,
    parameter bit INT_EN = 1'b1,
    localparam int RW = $clog2(NREG)
) (
    input  logic            T3,
    input  logic            CLR,
    input  logic [2:0]      SW,
    input  logic [OPW-1:0]  IR_OP,
    input  logic [RW-1:0]   IR_RD,
    input  logic [RW-1:0]   IR_RS,
    input  logic            C,
    input  logic            Z,
    input  logic            INTR,
    input  logic            STEP,
    output logic [3:1]      W,
    output logic            ST0,
    output logic [RW-1:0]   SEL_A,
    output logic [RW-1:0]   SEL_B,
    output logic [3:0]      S,
    output logic [16:0]     CTL,
    output logic            INTA,
    output logic            IE
);
    typedef enum logic [2:0] {W1 = 3'b001, W2 = 3'b010, W3 = 3'b100} beat_t;
    localparam logic [16:0] SELCTL = 17'h00001;
    localparam logic [16:0] DRW    = 17'h00002;
    localparam logic [16:0] LPC    = 17'h00004;
    localparam logic [16:0] PCINC  = 17'h00008;
    localparam logic [16:0] PCADD  = 17'h00010;
    localparam logic [16:0] LAR    = 17'h00020;
    localparam logic [16:0] ARINC  = 17'h00040;
    localparam logic [16:0] LIR    = 17'h00080;
    localparam logic [16:0] LDZ    = 17'h00100;
    localparam logic [16:0] LDC    = 17'h00200;
    localparam logic [16:0] CIN    = 17'h00400;
    localparam logic [16:0] M      = 17'h00800;
    localparam logic [16:0] MEMW   = 17'h01000;
    localparam logic [16:0] ABUS   = 17'h02000;
    localparam logic [16:0] SBUS   = 17'h04000;
    localparam logic [16:0] MBUS   = 17'h08000;
    localparam logic [16:0] STOP   = 17'h10000;

    beat_t         beat, beat_n;
    logic          st0_q, st0_n, ie_q, ie_n, irq_q, irq_n;
    logic [RW-1:0] cnt, cnt_n, sel_a, sel_b;
    logic [2:0]    sw_q;
    logic [3:0]    op, s;
    logic [16:0]   ctl;
    logic          inta, is_short, is_long, is_last;

    // opcodes with any bit set above bit 3 execute as NOP
    assign op = (IR_OP >> 4) != '0 ? 4'h0 : IR_OP[3:0];

    // state register; a console-mode change restarts sequencing from W1
    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            beat <= W1;
            st0_q <= 1'b0;
            cnt <= '0;
            ie_q <= 1'b0;
            irq_q <= 1'b0;
            sw_q <= 3'b000;
        end else if (SW != sw_q) begin
            beat <= W1;
            st0_q <= 1'b0;
            cnt <= '0;
            irq_q <= 1'b0;
            sw_q <= SW;
        end else begin
            beat <= beat_n;
            st0_q <= st0_n;
            cnt <= cnt_n;
            ie_q <= ie_n;
            irq_q <= irq_n;
        end
    end

    // decode strobes for the current beat and choose the next beat
    always_comb begin
        st0_n = st0_q;
        cnt_n = cnt;
        ie_n = ie_q;
        irq_n = 1'b0;
        is_short = 1'b0;
        is_long = 1'b0;
        is_last = 1'b0;
        ctl = '0;
        s = 4'b1111;
        sel_a = '0;
        sel_b = '0;
        inta = 1'b0;
        if (sw_q != 3'b000) begin
            is_short = 1'b1;
            ctl = SELCTL | STOP;
            case (sw_q)
                3'b100: begin ctl = ctl | SBUS | DRW; sel_a = cnt; cnt_n = cnt + 1'b1; end
                3'b011: begin sel_a = cnt; sel_b = cnt + 1'b1; cnt_n = cnt + RW'(2); end
                3'b001: begin ctl = ctl | (st0_q ? SBUS | MEMW | ARINC : SBUS | LAR); st0_n = 1'b1; end
                3'b010: begin ctl = ctl | (st0_q ? MBUS | ARINC : SBUS | LAR); st0_n = 1'b1; end
                default: ;
            endcase
        end else begin
            sel_a = IR_RD;
            sel_b = IR_RS;
            if (irq_q) begin
                is_short = 1'b1;
                inta = 1'b1;
                ctl = SBUS | LPC;
            end else if (!st0_q) begin
                is_short = 1'b1;
                ctl = SBUS | LPC;
                st0_n = 1'b1;
            end else if (beat == W1) begin
                ctl = LIR | PCINC;
            end else begin
                is_long = beat == W2 && (op == 4'h5 || op == 4'h6);
                is_last = !is_long;
                case (op)
                    4'h0: s = 4'b0000;
                    4'h1: begin s = 4'b1001; ctl = ABUS | DRW | LDZ | LDC | CIN; end
                    4'h2: begin s = 4'b0110; ctl = ABUS | DRW | LDZ | LDC; end
                    4'h3: begin s = 4'b1011; ctl = M | ABUS | DRW | LDZ; end
                    4'h4: begin s = 4'b0000; ctl = ABUS | DRW | LDZ | LDC; end
                    4'h5: begin s = is_long ? 4'b1010 : 4'b1111; ctl = is_long ? M | ABUS | LAR : MBUS | DRW; end
                    4'h6: begin s = is_long ? 4'b1111 : 4'b1010; ctl = is_long ? M | ABUS | LAR : M | ABUS | MEMW; end
                    4'h7: ctl = C ? PCADD : '0;
                    4'h8: ctl = Z ? PCADD : '0;
                    4'h9: ctl = M | ABUS | LPC;
                    4'hA: begin s = 4'b1010; ctl = M | ABUS; end
                    4'hB: begin s = 4'b1110; ctl = M | ABUS | DRW | LDZ; end
                    4'hC: begin s = 4'b0110; ctl = LDZ | LDC; end
                    4'hD: begin s = 4'b1010; ctl = M | ABUS | DRW; end
                    4'hE: ctl = STOP;
                    default: ie_n = IR_RS[0];
                endcase
                if (STEP && is_last) ctl = ctl | STOP;
                if (INT_EN && is_last && ie_q && INTR) begin
                    irq_n = 1'b1;
                    ie_n = 1'b0;
                end
            end
        end
        beat_n = beat == W1 ? (is_short ? W1 : W2) : (beat == W2 && is_long) ? W3 : W1;
        if (!INT_EN) ie_n = 1'b0;
    end

    assign W = beat;
    assign ST0 = st0_q;
    assign IE = ie_q;
    assign INTA = CLR & inta;
    assign CTL = CLR ? ctl : STOP;
    assign S = CLR ? s : 4'b1111;
    assign SEL_A = CLR ? sel_a : '0;
    assign SEL_B = CLR ? sel_b : '0;
endmodule

// File: doc/hw_seq_ctrl.md
HW_SEQ_CTRL -- requirements
Module: hw_seq_ctrl

Interface
REQ-001 SHALL expose parameter NREG, default 4, number of general registers; power of two, 2..16; RW = log2(NREG).
REQ-002 SHALL expose parameter OPW, default 4, opcode field width (>=4); any nonzero bit above bit 3 decodes as NOP.
REQ-003 SHALL expose parameter INT_EN, default 1, interrupt logic present; when 0, INTA and IE are tied 0.
REQ-004 SHALL have ports:
  T3  in  1  clock, rising edge active.
  CLR  in  1  asynchronous active-low reset.
  SW  in  3  console mode: 100 write reg, 011 read reg, 001 write mem, 010 read mem, 000 run.
  IR_OP  in  OPW  instruction opcode.
  IR_RD  in  RW  destination register field.
  IR_RS  in  RW  source register field.
  C, Z  in  1 each  ALU carry and zero flags.
  INTR  in  1  interrupt request, level.
  STEP  in  1  single-instruction step enable.
  W  out  3  one-hot beat, W[1]..W[3].
  ST0  out  1  phase flag.
  SEL_A, SEL_B  out  RW each  ALU A and B register selects.
  S  out  4  ALU function.
  CTL  out  17  strobes, bit0..16: SELCTL DRW LPC PCINC PCADD LAR ARINC LIR LDZ LDC CIN M MEMW ABUS SBUS MBUS STOP.
  INTA  out  1  interrupt acknowledge.
  IE  out  1  interrupt enable status.

Function
REQ-005 Beat generator SHALL advance one step per T3 edge: W1->W2 unless SHORT; W2->W3 only if LONG, else W1; W3->W1.
REQ-006 SHORT SHALL be set for every console-mode beat, for the run-mode ST0=0 beat, and for the interrupt cycle. LONG SHALL be set in W2 of LD and ST.
REQ-007 SW SHALL be registered each edge. A change of SW SHALL clear ST0, reg_cnt and the beat (to W1) on that edge.
REQ-008 Write reg: each beat SHALL assert SBUS, DRW and SELCTL with SEL_A = reg_cnt; reg_cnt SHALL increment mod NREG.
REQ-009 Read reg: each beat SHALL set SEL_A = reg_cnt and SEL_B = reg_cnt+1; reg_cnt SHALL advance by 2 mod NREG.
REQ-010 Write mem: with ST0=0, assert SBUS and LAR, then ST0<-1. With ST0=1, assert SBUS, MEMW and ARINC.
REQ-011 Read mem: with ST0=0, assert SBUS and LAR, then ST0<-1. With ST0=1, assert MBUS and ARINC.
REQ-012 Every console beat SHALL assert STOP and SELCTL.
REQ-013 Run mode, ST0=0: W1 SHALL assert SBUS and LPC, then ST0<-1. With ST0=1, each W1 SHALL assert LIR and PCINC.
REQ-014 Execute beats, opcode (S in W2 / S in W3; other strobes):
  0 NOP: S=0000; no strobes.
  1 ADD: S=1001; ABUS DRW LDZ LDC CIN.
  2 SUB: S=0110; ABUS DRW LDZ LDC.
  3 AND: S=1011; M ABUS DRW LDZ.
  4 INC: S=0000; ABUS DRW LDZ LDC.
  5 LD: S=1010; W2 M ABUS LAR; W3 MBUS DRW.
  6 ST: S=1111 / 1010; W2 M ABUS LAR; W3 M ABUS MEMW.
  7 JC: PCADD if C.
  8 JZ: PCADD if Z.
  9 JMP: S=1111; M ABUS LPC.
  A OUT: S=1010; M ABUS.
  B OR: S=1110; M ABUS DRW LDZ.
  C CMP: S=0110; LDZ LDC.
  D MOV: S=1010; M ABUS DRW.
  E STP: STOP in W2.
  F: IE<-IR_RS[0].
  S SHALL be 1111 for all unlisted opcode/beat pairs.
REQ-015 In run mode, SEL_A SHALL equal IR_RD and SEL_B SHALL equal IR_RS.
REQ-016 Interrupt: if INT_EN, IE=1 and INTR=1 on an instruction's last beat, the next beat SHALL be a single W1 interrupt cycle.
REQ-017 The interrupt cycle SHALL assert INTA, SBUS and LPC (vector load), SHALL clear IE, and SHALL NOT assert LIR.
REQ-018 An EI/DI instruction and an interrupt completing on the same edge SHALL leave IE=0.
REQ-019 When STEP=1, STOP SHALL assert on the last beat of each instruction; STOP SHALL NOT assert during an interrupt cycle.

Reset
REQ-020 While CLR=0: W=001, ST0=0, reg_cnt=0, IE=0, INTA=0, S=1111, CTL=0 except STOP=1. Reset SHALL abort any instruction.

Verification
REQ-021 Reset mid-LD in W3 -> W=001, ST0=0, STOP=1, DRW=0 immediately.
REQ-022 NREG=8, SW=100, 9 edges -> SEL_A sequence 0..7 then 0, DRW=1 every beat.
REQ-023 SW=000, opcode 6 (ST) -> W sequence 001,010,100; MEMW=1 only in W3; S=1111 then 1010.
REQ-024 IE=1, INTR=1 during ADD W2 -> next beat INTA=1, LPC=1, LIR=0; IE=0 afterwards.
REQ-025 Opcode 7 with C=0, then C=1 -> PCADD 0 then 1 in W2; W3 never entered.
